// File: rtl/vec_store_sequencer_if.sv
// rtl/vec_store_sequencer_if.sv - vector input and memory write port bundle
interface vec_store_sequencer_if #(
  parameter int LANES  = 16,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic                    vec_valid;
  logic                    vec_ready;
  logic [LANES*DATA_W-1:0] vec_data;
  logic [ADDR_W-1:0]       vec_base_addr;
  logic [LANES-1:0]        vec_lane_mask;
  logic                    mem_we;
  logic [ADDR_W-1:0]       mem_addr;
  logic [DATA_W-1:0]       mem_wdata;
  logic                    mem_ready;

  // producer of vectors and the responding memory
  modport master (
    output vec_valid, vec_data, vec_base_addr, vec_lane_mask, mem_ready,
    input  vec_ready, mem_we, mem_addr, mem_wdata
  );

  // the sequencer itself
  modport slave (
    input  vec_valid, vec_data, vec_base_addr, vec_lane_mask, mem_ready,
    output vec_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/vec_store_sequencer.sv
// rtl/vec_store_sequencer.sv - writes enabled lanes of one vector as word stores
module vec_store_sequencer #(
  parameter int LANES       = 16,
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int ADDR_STRIDE = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  vec_store_sequencer_if.slave     bus,
  output logic                     busy,
  output logic                     done,
  output logic [$clog2(LANES):0]   lanes_written
);
  localparam int IDX_W = $clog2(LANES);
  localparam int CNT_W = IDX_W + 1;

  typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;

  state_t                  state_q, state_d;
  logic [LANES*DATA_W-1:0] data_q, data_d;
  logic [ADDR_W-1:0]       base_q, base_d;
  logic [LANES-1:0]        mask_q, mask_d;
  logic [CNT_W-1:0]        count_q, count_d;
  logic                    vec_ready_q, vec_ready_d;
  logic                    mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]       mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]       mem_wdata_q, mem_wdata_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic [CNT_W-1:0]        lw_q, lw_d;

  logic [LANES-1:0]        rest_mask;
  logic [IDX_W-1:0]        idx_in;
  logic [IDX_W-1:0]        idx_next;

  // Lowest set bit wins, so lanes go out in ascending order.
  function automatic logic [IDX_W-1:0] lowest(input logic [LANES-1:0] m);
    lowest = '0;
    for (int i = LANES - 1; i >= 0; i--) begin
      if (m[i]) lowest = IDX_W'(i);
    end
  endfunction

  // Address arithmetic is modulo 2^ADDR_W, so bases near the top wrap to zero.
  function automatic logic [ADDR_W-1:0] lane_addr(input logic [ADDR_W-1:0] base,
                                                  input logic [IDX_W-1:0]  idx);
    lane_addr = base + ADDR_W'(idx) * ADDR_W'(ADDR_STRIDE);
  endfunction

  assign bus.vec_ready = vec_ready_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign lanes_written = lw_q;

  // Remaining mask with the lane currently on the bus removed.
  assign rest_mask = mask_q & (mask_q - 1'b1);
  assign idx_in    = lowest(bus.vec_lane_mask);
  assign idx_next  = lowest(rest_mask);

  // Next-state and next-output decode; every output is registered below.
  always_comb begin
    state_d     = state_q;
    data_d      = data_q;
    base_d      = base_q;
    mask_d      = mask_q;
    count_d     = count_q;
    vec_ready_d = vec_ready_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    lw_d        = lw_q;
    case (state_q)
      IDLE: begin
        vec_ready_d = 1'b1;
        if (bus.vec_valid && vec_ready_q) begin
          data_d      = bus.vec_data;
          base_d      = bus.vec_base_addr;
          mask_d      = bus.vec_lane_mask;
          count_d     = '0;
          vec_ready_d = 1'b0;
          if (bus.vec_lane_mask != '0) begin
            state_d     = WRITE;
            busy_d      = 1'b1;
            mem_we_d    = 1'b1;
            mem_addr_d  = lane_addr(bus.vec_base_addr, idx_in);
            mem_wdata_d = bus.vec_data[idx_in*DATA_W +: DATA_W];
          end else begin
            state_d = DONE;
            done_d  = 1'b1;
            lw_d    = '0;
          end
        end
      end
      WRITE: begin
        // Without mem_ready everything holds, which keeps the bus stable.
        if (mem_we_q && bus.mem_ready) begin
          mask_d  = rest_mask;
          count_d = count_q + 1'b1;
          if (rest_mask != '0) begin
            mem_addr_d  = lane_addr(base_q, idx_next);
            mem_wdata_d = data_q[idx_next*DATA_W +: DATA_W];
          end else begin
            state_d  = DONE;
            mem_we_d = 1'b0;
            busy_d   = 1'b0;
            done_d   = 1'b1;
            lw_d     = count_q + 1'b1;
          end
        end
      end
      DONE: begin
        state_d     = IDLE;
        vec_ready_d = 1'b1;
      end
      default: begin
        state_d     = IDLE;
        vec_ready_d = 1'b1;
        mem_we_d    = 1'b0;
        busy_d      = 1'b0;
      end
    endcase
  end

  // State and output registers; reset abandons any vector in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      data_q      <= '0;
      base_q      <= '0;
      mask_q      <= '0;
      count_q     <= '0;
      vec_ready_q <= 1'b1;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      lw_q        <= '0;
    end else begin
      state_q     <= state_d;
      data_q      <= data_d;
      base_q      <= base_d;
      mask_q      <= mask_d;
      count_q     <= count_d;
      vec_ready_q <= vec_ready_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      lw_q        <= lw_d;
    end
  end
endmodule

// File: tb/tb_vec_store_sequencer.sv
// tb/tb_vec_store_sequencer.sv - self-checking bench for vec_store_sequencer
module tb_vec_store_sequencer;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       busy;
  logic       done;
  logic [4:0] lanes_written;

  vec_store_sequencer_if #(.LANES(16), .DATA_W(32), .ADDR_W(32)) bus ();

  vec_store_sequencer #(.LANES(16), .DATA_W(32), .ADDR_W(32), .ADDR_STRIDE(4)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .bus           (bus),
    .busy          (busy),
    .done          (done),
    .lanes_written (lanes_written)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int acc_cyc = -1000;
  bit stall_en = 1'b0;

  // model state
  int          m_phase = 0;
  logic [31:0] m_q_addr[$];
  logic [31:0] m_q_data[$];
  int          m_cnt = 0;
  int          m_lw = 0;

  // observation logs
  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];
  int          wr_rel[$];
  int          done_rel[$];
  int          acc_log[$];
  int          we_cycles = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [511:0] mk(input logic [31:0] b);
    for (int i = 0; i < 16; i++) mk[i*32 +: 32] = b + 32'(i);
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // memory side: ready unless a stall window is requested
  always @(posedge clk) begin
    #1;
    bus.mem_ready = !(stall_en && (cyc - acc_cyc) >= 6 && (cyc - acc_cyc) <= 8);
  end

  // reference model and per-cycle comparison
  always @(negedge clk) begin
    if (!rst_n) begin
      m_phase = 0; m_q_addr.delete(); m_q_data.delete(); m_cnt = 0; m_lw = 0;
      chk("rst_vec_ready", bus.vec_ready, 1);
      chk("rst_mem_we", bus.mem_we, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_lanes_written", lanes_written, 0);
    end else begin
      chk("vec_ready", bus.vec_ready, m_phase == 0);
      chk("mem_we", bus.mem_we, m_phase == 1);
      chk("busy", busy, m_phase == 1);
      chk("done", done, m_phase == 2);
      chk("lanes_written", lanes_written, 64'(m_lw));
      if (m_phase == 1 && m_q_addr.size() > 0) begin
        chk("mem_addr", bus.mem_addr, m_q_addr[0]);
        chk("mem_wdata", bus.mem_wdata, m_q_data[0]);
      end
      if (bus.mem_we) we_cycles++;
      if (bus.mem_we && bus.mem_ready) begin
        wr_addr.push_back(bus.mem_addr);
        wr_data.push_back(bus.mem_wdata);
        wr_rel.push_back(cyc - acc_cyc);
      end
      if (done) done_rel.push_back(cyc - acc_cyc);
      case (m_phase)
        0: if (bus.vec_valid) begin
          acc_cyc = cyc;
          acc_log.push_back(cyc);
          m_cnt = 0;
          for (int i = 0; i < 16; i++) begin
            if (bus.vec_lane_mask[i]) begin
              m_q_addr.push_back(bus.vec_base_addr + 32'(i * 4));
              m_q_data.push_back(bus.vec_data[i*32 +: 32]);
            end
          end
          if (m_q_addr.size() > 0) m_phase = 1;
          else begin m_phase = 2; m_lw = 0; end
        end
        1: if (bus.mem_ready) begin
          void'(m_q_addr.pop_front());
          void'(m_q_data.pop_front());
          m_cnt++;
          if (m_q_addr.size() == 0) begin m_phase = 2; m_lw = m_cnt; end
        end
        default: m_phase = 0;
      endcase
    end
  end

  task automatic clear_logs();
    wr_addr.delete(); wr_data.delete(); wr_rel.delete();
    done_rel.delete(); acc_log.delete(); we_cycles = 0;
  endtask

  task automatic offer(input logic [511:0] d, input logic [31:0] base, input logic [15:0] mask);
    bit ok = 1'b0;
    @(posedge clk); #1;
    bus.vec_valid = 1'b1; bus.vec_data = d; bus.vec_base_addr = base; bus.vec_lane_mask = mask;
    for (int n = 0; n < 100 && !ok; n++) begin
      @(negedge clk);
      if (bus.vec_ready) ok = 1'b1;
    end
    if (!ok) chk("accept_timeout", 0, 1);
    @(posedge clk); #1;
    bus.vec_valid = 1'b0; bus.vec_data = '1; bus.vec_lane_mask = 16'hFFFF;
  endtask

  task automatic wait_done();
    bit ok = 1'b0;
    for (int n = 0; n < 200 && !ok; n++) begin
      @(negedge clk);
      if (done) ok = 1'b1;
    end
    if (!ok) chk("done_timeout", 0, 1);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    bus.vec_valid = 1'b0; bus.vec_data = '0; bus.vec_base_addr = '0; bus.vec_lane_mask = '0;
    bus.mem_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_addr", bus.mem_addr, 0);
    chk("reset_wdata", bus.mem_wdata, 0);
    @(posedge clk); #1 rst_n = 1'b1;

    // full mask
    clear_logs();
    offer(mk(32'hA000_0000), 32'h1000, 16'hFFFF);
    wait_done();
    chk("full_count", wr_addr.size(), 16);
    chk("full_first_rel", wr_rel[0], 1);
    chk("full_last_rel", wr_rel[15], 16);
    chk("full_addr0", wr_addr[0], 32'h1000);
    chk("full_addr15", wr_addr[15], 32'h103C);
    chk("full_data15", wr_data[15], 32'hA000_000F);
    chk("full_done_rel", done_rel[0], 17);
    chk("full_lw", lanes_written, 16);
    @(negedge clk);
    chk("full_ready_rel", cyc - acc_cyc, 18);
    chk("full_ready", bus.vec_ready, 1);

    // sparse mask
    clear_logs();
    offer(mk(32'hA000_0000), 32'h1000, 16'h8001);
    wait_done();
    chk("sparse_count", wr_addr.size(), 2);
    chk("sparse_addr0", wr_addr[0], 32'h1000);
    chk("sparse_data0", wr_data[0], 32'hA000_0000);
    chk("sparse_addr1", wr_addr[1], 32'h103C);
    chk("sparse_data1", wr_data[1], 32'hA000_000F);
    chk("sparse_rel1", wr_rel[1], 2);
    chk("sparse_done_rel", done_rel[0], 3);
    chk("sparse_lw", lanes_written, 2);

    // backpressure on lane 5
    clear_logs();
    stall_en = 1'b1;
    offer(mk(32'hB000_0000), 32'h1000, 16'hFFFF);
    wait_done();
    stall_en = 1'b0;
    chk("bp_count", wr_addr.size(), 16);
    chk("bp_we_cycles", we_cycles, 19);
    chk("bp_lane5_addr", wr_addr[5], 32'h1014);
    chk("bp_lane5_rel", wr_rel[5], 9);
    chk("bp_lane6_rel", wr_rel[6], 10);
    chk("bp_done_rel", done_rel[0], 20);

    // empty mask
    clear_logs();
    offer(mk(32'hC000_0000), 32'h1000, 16'h0000);
    wait_done();
    chk("empty_we_cycles", we_cycles, 0);
    chk("empty_done_rel", done_rel[0], 1);
    chk("empty_lw", lanes_written, 0);
    @(negedge clk);
    chk("empty_ready_rel", cyc - acc_cyc, 2);
    chk("empty_ready", bus.vec_ready, 1);

    // address wrap
    clear_logs();
    offer(mk(32'hD000_0000), 32'hFFFF_FFF8, 16'hFFFF);
    wait_done();
    chk("wrap_addr0", wr_addr[0], 32'hFFFF_FFF8);
    chk("wrap_addr1", wr_addr[1], 32'hFFFF_FFFC);
    chk("wrap_addr2", wr_addr[2], 32'h0000_0000);
    chk("wrap_addr15", wr_addr[15], 32'h0000_0034);

    // reset after seven completed writes
    clear_logs();
    offer(mk(32'hE000_0000), 32'h4000, 16'hFFFF);
    for (int n = 0; n < 50 && wr_addr.size() < 7; n++) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_mem_we", bus.mem_we, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_count", wr_addr.size(), 7);
    chk("midrst_ready", bus.vec_ready, 1);
    clear_logs();
    offer(mk(32'hF000_0000), 32'h5000, 16'hFFFF);
    wait_done();
    chk("after_rst_addr0", wr_addr[0], 32'h5000);
    chk("after_rst_data0", wr_data[0], 32'hF000_0000);
    chk("after_rst_lw", lanes_written, 16);

    // valid while busy is ignored until the next IDLE cycle
    clear_logs();
    offer(mk(32'h5000_0000), 32'h3000, 16'h00F0);
    offer(mk(32'h6000_0000), 32'h2000, 16'h0003);
    wait_done();
    chk("ign_count", wr_addr.size(), 6);
    chk("ign_a_addr0", wr_addr[0], 32'h3010);
    chk("ign_a_data0", wr_data[0], 32'h5000_0004);
    chk("ign_a_addr3", wr_addr[3], 32'h301C);
    chk("ign_a_data3", wr_data[3], 32'h5000_0007);
    chk("ign_b_addr0", wr_addr[4], 32'h2000);
    chk("ign_b_data1", wr_data[5], 32'h6000_0001);
    chk("ign_accept_gap", acc_log[1] - acc_log[0], 6);
    chk("ign_lw", lanes_written, 2);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
